// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter
// between NUM_REQ byte-stream requesters. The owner keeps the transmitter
// until its byte marked last has been fully framed out.
// Optional watchdog: define UART_ARB_WDOG_EN to abort packets whose bytes
// stall for WDOG_CYCLES cycles (sticky wdog_err).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WDOG_CYCLES = 200000
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tdata,
  output logic                 send,
  input  logic                 trdy,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 wdog_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitLow,
    StWaitHigh,
    StNext
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   gidx_q;
  logic              last_flag_q;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand;
  logic              g_req;
  logic              g_last;
  logic [7:0]        g_data;

  // Round-robin pick: first requester set searching upward from rr_ptr+1.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = IdxW'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Select the current owner's request, last flag and byte.
  always_comb begin
    g_req  = 1'b0;
    g_last = 1'b0;
    g_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gidx_q == IdxW'(i)) begin
        g_req  = req[i];
        g_last = req_last[i];
        g_data = req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_WDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_err_q;
  logic        advance;

  // Any progress in a counting state restarts the watchdog.
  always_comb begin
    advance = 1'b0;
    unique case (state_q)
      StLoad:     advance = g_req && trdy;
      StWaitLow:  advance = !trdy;
      StWaitHigh: advance = trdy;
      default:    advance = 1'b0;
    endcase
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  // Arbiter FSM with registered outputs; strobes default low each cycle.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= IdxW'(NUM_REQ - 1);
      gidx_q      <= '0;
      last_flag_q <= 1'b0;
      grant       <= '0;
      req_ack     <= '0;
      send        <= 1'b0;
      pkt_done    <= 1'b0;
      busy        <= 1'b0;
      tdata       <= 8'h00;
`ifdef UART_ARB_WDOG_EN
      wdog_cnt_q  <= '0;
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      send     <= 1'b0;
      req_ack  <= '0;
      pkt_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            gidx_q  <= pick_idx;
            grant   <= NUM_REQ'(1) << pick_idx;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (g_req && trdy) begin
            tdata           <= g_data;
            send            <= 1'b1;
            req_ack[gidx_q] <= 1'b1;
            last_flag_q     <= g_last;
            state_q         <= StWaitLow;
          end
        end
        StWaitLow: begin
          if (!trdy) state_q <= StWaitHigh;
        end
        StWaitHigh: begin
          if (trdy) state_q <= StNext;
        end
        StNext: begin
          if (last_flag_q) begin
            pkt_done <= 1'b1;
            rr_ptr_q <= gidx_q;
            grant    <= '0;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end else begin
            state_q <= StLoad;
          end
        end
        default: begin
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
`ifdef UART_ARB_WDOG_EN
      // Later assignments override the FSM on abort; advance is 0 then.
      if (state_q == StLoad || state_q == StWaitLow || state_q == StWaitHigh) begin
        if (advance) begin
          wdog_cnt_q <= '0;
        end else if (wdog_cnt_q == WDOG_CYCLES - 1) begin
          wdog_cnt_q <= '0;
          wdog_err_q <= 1'b1;
          grant      <= '0;
          busy       <= 1'b0;
          rr_ptr_q   <= gidx_q;
          state_q    <= StIdle;
        end else begin
          wdog_cnt_q <= wdog_cnt_q + 32'd1;
        end
      end else begin
        wdog_cnt_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural
// transmitter (trdy drops after send, returns after Frame cycles) and
// requester models that advance on req_ack.
module tb_uart_tx_arbiter;

  localparam int Frame  = 6;
  localparam int TbWdog = 50;

  logic        mclk     = 1'b0;
  logic        reset    = 1'b0;
  logic [3:0]  req      = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic [7:0]  tdata;
  logic        send;
  logic        trdy     = 1'b1;
  logic        busy;
  logic        pkt_done;
  logic        wdog_err;

  int checks = 0;
  int errors = 0;

  int         len    [4];
  int         pos    [4];
  bit         active [4];
  bit         hold   [4];
  logic [7:0] base   [4];

  logic [7:0] tdata_log[$];
  logic [3:0] grant_log[$];
  int         pd_cnt;
  logic [3:0] ack_seen;

  bit   tx_stuck  = 1'b0;
  int   frame_cnt = 0;
  logic prev_send = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .WDOG_CYCLES (TbWdog)
  ) dut (
    .mclk     (mclk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .grant    (grant),
    .tdata    (tdata),
    .send     (send),
    .trdy     (trdy),
    .busy     (busy),
    .pkt_done (pkt_done),
    .wdog_err (wdog_err)
  );

  always #5 mclk = ~mclk;

  // Transmitter model: busy for Frame cycles after each send.
  always @(posedge mclk) begin
    if (send) begin
      trdy      <= 1'b0;
      frame_cnt <= Frame;
    end else if (frame_cnt == 1) begin
      if (!tx_stuck) begin
        trdy      <= 1'b1;
        frame_cnt <= 0;
      end
    end else if (frame_cnt > 1) begin
      frame_cnt <= frame_cnt - 1;
    end
  end

  // Protocol monitor on the send strobe.
  always @(negedge mclk) begin
    if (send) begin
      checks++;
      if (prev_send) begin
        errors++;
        $display("FAIL send_twice: send high on consecutive cycles, required single-cycle");
      end
      if (!trdy) begin
        errors++;
        $display("FAIL send_trdy_low: send=1 while trdy=%b, required trdy=1", trdy);
      end
    end
    prev_send <= send;
  end

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req[i]            = active[i] && !hold[i];
      req_data[8*i +: 8] = base[i] + 8'(pos[i]);
      req_last[i]       = (pos[i] == len[i] - 1);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      active[i] = 1'b0;
      hold[i]   = 1'b0;
      pos[i]    = 0;
      len[i]    = 0;
      base[i]   = 8'(i * 16);
    end
    tdata_log.delete();
    grant_log.delete();
    pd_cnt = 0;
    drive_reqs();
  endtask

  // One clock: observe outputs at negedge, then advance requester models.
  task automatic step();
    @(posedge mclk);
    @(negedge mclk);
    ack_seen = req_ack;
    if (send) begin
      tdata_log.push_back(tdata);
      grant_log.push_back(grant);
    end
    if (pkt_done) pd_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        if (pos[i] == len[i] - 1) begin
          active[i] = 1'b0;
          pos[i]    = 0;
        end else begin
          pos[i]++;
        end
      end
    end
    drive_reqs();
  endtask

  task automatic reset_dut();
    @(negedge mclk);
    reset = 1'b0;
    repeat (2) @(negedge mclk);
    drive_reqs();
    reset = 1'b1;
  endtask

  task automatic wait_ack(input int idx, input string name);
    int n = 0;
    ack_seen = '0;
    while (!ack_seen[idx] && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!ack_seen[idx]) begin
      errors++;
      $display("FAIL %s: no req_ack[%0d] within 40 cycles", name, idx);
    end
  endtask

  task automatic wait_pd(input int target, input int budget, input string name);
    int n = 0;
    while (pd_cnt < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (pd_cnt < target) begin
      errors++;
      $display("FAIL %s: pkt_done count %0d after %0d cycles, required %0d", name, pd_cnt,
               budget, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_all();
    repeat (3) @(negedge mclk);
    checks++;
    if ({grant, req_ack, send, pkt_done, busy, wdog_err, tdata} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: grant=%b ack=%b send=%b pd=%b busy=%b wdog=%b tdata=%h, required all 0",
               grant, req_ack, send, pkt_done, busy, wdog_err, tdata);
    end
  endtask

  task automatic test_single();
    clear_all();
    active[0] = 1'b1;
    len[0]    = 1;
    base[0]   = 8'h41;
    drive_reqs();
    reset = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || send !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b send=%b, required 0001 1 0", grant, busy, send);
    end
    step();
    checks++;
    if (send !== 1'b1 || tdata !== 8'h41 || ack_seen !== 4'b0001) begin
      errors++;
      $display("FAIL single_send: send=%b tdata=%h ack=%b, required 1 41 0001", send, tdata, ack_seen);
    end
    wait_pd(1, 40, "single_pkt_done");
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: grant=%b busy=%b, required 0000 0", grant, busy);
    end
    repeat (5) step();
    checks++;
    if (pd_cnt !== 1) begin
      errors++;
      $display("FAIL single_pd_once: pkt_done count %0d, required 1", pd_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    logic [3:0] exp_g;
    logic [3:0] one;
    clear_all();
    for (int i = 0; i < 4; i++) begin
      active[i] = 1'b1;
      len[i]    = 2;
    end
    reset_dut();
    wait_pd(4, 200, "rr_pkt_done");
    checks++;
    if (tdata_log.size() != 8) begin
      errors++;
      $display("FAIL rr_count: %0d bytes sent, required 8", tdata_log.size());
    end
    one = 4'b0001;
    for (int k = 0; k < 8 && k < tdata_log.size(); k++) begin
      exp_d = 8'((k / 2) * 16 + (k % 2));
      exp_g = one << (k / 2);
      checks++;
      if (tdata_log[k] !== exp_d || grant_log[k] !== exp_g) begin
        errors++;
        $display("FAIL rr_byte%0d: tdata=%h grant=%b, required %h %b", k, tdata_log[k],
                 grant_log[k], exp_d, exp_g);
      end
    end
  endtask

  task automatic test_stall();
    clear_all();
    active[2] = 1'b1;
    len[2]    = 2;
    reset_dut();
    wait_ack(2, "stall_first_ack");
    active[1] = 1'b1;
    len[1]    = 1;
    hold[2]   = 1'b1;
    drive_reqs();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (send !== 1'b0 || grant !== 4'b0100) begin
        errors++;
        $display("FAIL stall_gap%0d: send=%b grant=%b, required 0 0100", c, send, grant);
      end
    end
    hold[2] = 1'b0;
    drive_reqs();
    wait_pd(2, 100, "stall_pkt_done");
    checks++;
    if (tdata_log.size() != 3) begin
      errors++;
      $display("FAIL stall_count: %0d bytes sent, required 3", tdata_log.size());
    end else begin
      checks++;
      if (tdata_log[1] !== 8'h21 || grant_log[1] !== 4'b0100 ||
          tdata_log[2] !== 8'h10 || grant_log[2] !== 4'b0010) begin
        errors++;
        $display("FAIL stall_order: %h/%b then %h/%b, required 21/0100 then 10/0010",
                 tdata_log[1], grant_log[1], tdata_log[2], grant_log[2]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_all();
    active[0] = 1'b1;
    len[0]    = 3;
    reset_dut();
    wait_ack(0, "midrst_ack");
    step();
    step();
    checks++;
    if (busy !== 1'b1 || trdy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_frame: busy=%b trdy=%b, required 1 0", busy, trdy);
    end
    reset     = 1'b0;
    active[0] = 1'b0;
    pos[0]    = 0;
    active[2] = 1'b1;
    len[2]    = 1;
    drive_reqs();
    step();
    checks++;
    if (grant !== 4'b0000 || send !== 1'b0 || busy !== 1'b0 || tdata !== 8'h00 ||
        req_ack !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_state: grant=%b send=%b busy=%b tdata=%h ack=%b, required all 0",
               grant, send, busy, tdata, req_ack);
    end
    reset = 1'b1;
    tdata_log.delete();
    grant_log.delete();
    pd_cnt = 0;
    wait_pd(1, 60, "midrst_pkt_done");
    checks++;
    if (tdata_log.size() != 1 || tdata_log[0] !== 8'h20 || grant_log[0] !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_serve: %0d bytes, first %h/%b, required 1 byte 20/0100",
               tdata_log.size(), (tdata_log.size() > 0) ? tdata_log[0] : 8'hxx,
               (grant_log.size() > 0) ? grant_log[0] : 4'bxxxx);
    end
  endtask

`ifdef UART_ARB_WDOG_EN
  task automatic test_watchdog();
    int n = 0;
    clear_all();
    active[0] = 1'b1;
    len[0]    = 2;
    reset_dut();
    tx_stuck = 1'b1;
    wait_ack(0, "wdog_ack");
    while (wdog_err !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (wdog_err !== 1'b1 || n < TbWdog - 5 || n > TbWdog + 10) begin
      errors++;
      $display("FAIL wdog_fire: wdog_err=%b after %0d cycles, required 1 near %0d", wdog_err, n,
               TbWdog);
    end
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || pd_cnt !== 0) begin
      errors++;
      $display("FAIL wdog_abort: grant=%b busy=%b pkt_done=%0d, required 0000 0 0", grant, busy,
               pd_cnt);
    end
    tx_stuck  = 1'b0;
    active[0] = 1'b0;
    pos[0]    = 0;
    active[1] = 1'b1;
    len[1]    = 1;
    drive_reqs();
    tdata_log.delete();
    grant_log.delete();
    wait_pd(1, 60, "wdog_recover");
    checks++;
    if (tdata_log.size() != 1 || tdata_log[0] !== 8'h10 || grant_log[0] !== 4'b0010 ||
        wdog_err !== 1'b1) begin
      errors++;
      $display("FAIL wdog_next: %0d bytes wdog_err=%b, required 1 byte 10/0010 and sticky err",
               tdata_log.size(), wdog_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid_packet();
`ifdef UART_ARB_WDOG_EN
    test_watchdog();
`endif
    repeat (2) @(negedge mclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
